// File: rtl/char_fetch_ctrl.sv
// Text-mode character fetch controller: reads char/attr words, looks up glyph rows
// and queues {bitmap, attr} in a FWFT FIFO. Optional macro: CHAR_FETCH_UNDERLINE_EN.
module char_fetch_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [12:0] row_base_i,
  input  logic [6:0]  cols_i,
  input  logic [2:0]  scanline_i,
  output logic        tr_req_o,
  output logic [12:0] tr_adr_o,
  input  logic        tr_ack_i,
  input  logic [15:0] tr_dat_i,
  output logic        cc_ce_o,
  output logic [8:0]  cc_code_o,
  output logic [2:0]  cc_scan_o,
  input  logic [8:0]  cc_bmp_i,
  output logic        out_valid_o,
  input  logic        out_rdy_i,
  output logic [8:0]  out_bmp_o,
  output logic [6:0]  out_attr_o,
  output logic        busy_o,
  output logic        line_done_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    GLYPH,
    WAIT1,
    WAIT2,
    PUSH
  } state_t;

  state_t      state;
  logic [12:0] row_base;
  logic [6:0]  cols;
  logic [6:0]  col;
  logic [6:0]  col_next;
  logic [2:0]  scan;
  logic [6:0]  attr;
  logic [8:0]  bitmap;
  logic [8:0]  glyph_bits;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [15:0]      head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             flush;

  assign col_next = col + 7'd1;

`ifdef CHAR_FETCH_UNDERLINE_EN
  // Underline: the bottom glyph row of an attr[6] cell is forced solid.
  assign glyph_bits = (attr[6] && (scan == 3'd7)) ? 9'h1FF : cc_bmp_i;
`else
  assign glyph_bits = cc_bmp_i;
`endif

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign flush = line_start_i && (state != IDLE);
  // A full FIFO refuses the push even if a pop frees a slot in the same cycle.
  assign push  = (state == PUSH) && !full && !flush;
  assign pop   = !empty && out_rdy_i;

  assign head        = mem[rd_ptr];
  assign out_valid_o = !empty;
  assign out_bmp_o   = empty ? 9'h000 : head[15:7];
  assign out_attr_o  = empty ? 7'h00 : head[6:0];
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {bitmap, attr};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (!push && pop) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // A line start in any state (re)starts the line; outside IDLE it is an abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      row_base    <= '0;
      cols        <= '0;
      col         <= '0;
      scan        <= '0;
      attr        <= '0;
      bitmap      <= '0;
      tr_req_o    <= 1'b0;
      tr_adr_o    <= '0;
      cc_ce_o     <= 1'b0;
      cc_code_o   <= '0;
      cc_scan_o   <= '0;
      line_done_o <= 1'b0;
    end else begin
      cc_ce_o     <= 1'b0;
      line_done_o <= 1'b0;
      if (line_start_i) begin
        row_base <= row_base_i;
        cols     <= cols_i;
        scan     <= scanline_i;
        col      <= '0;
        tr_req_o <= 1'b1;
        tr_adr_o <= row_base_i;
        state    <= FETCH;
      end else begin
        case (state)
          IDLE: begin
          end
          FETCH: begin
            if (tr_ack_i) begin
              tr_req_o  <= 1'b0;
              attr      <= tr_dat_i[15:9];
              cc_code_o <= tr_dat_i[8:0];
              cc_scan_o <= scan;
              cc_ce_o   <= 1'b1;
              state     <= GLYPH;
            end
          end
          GLYPH: begin
            state <= WAIT1;
          end
          WAIT1: begin
            state <= WAIT2;
          end
          WAIT2: begin
            bitmap <= glyph_bits;
            state  <= PUSH;
          end
          PUSH: begin
            if (!full) begin
              if (col == cols) begin
                line_done_o <= 1'b1;
                state       <= IDLE;
              end else begin
                col      <= col_next;
                tr_req_o <= 1'b1;
                tr_adr_o <= row_base + {6'd0, col_next};
                state    <= FETCH;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_char_fetch_ctrl.sv
// Scoreboard bench for char_fetch_ctrl with text-RAM and char-RAM responder models.
// Expected FIFO words are queued at stimulus time and popped by a separate monitor.
module tb_char_fetch_ctrl;

  localparam int FIFO_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        line_start_i;
  logic [12:0] row_base_i;
  logic [6:0]  cols_i;
  logic [2:0]  scanline_i;
  logic        tr_req_o;
  logic [12:0] tr_adr_o;
  logic        tr_ack_i;
  logic [15:0] tr_dat_i;
  logic        cc_ce_o;
  logic [8:0]  cc_code_o;
  logic [2:0]  cc_scan_o;
  logic [8:0]  cc_bmp_i;
  logic        out_valid_o;
  logic        out_rdy_i;
  logic [8:0]  out_bmp_o;
  logic [6:0]  out_attr_o;
  logic        busy_o;
  logic        line_done_o;

  char_fetch_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .line_start_i(line_start_i),
    .row_base_i(row_base_i),
    .cols_i(cols_i),
    .scanline_i(scanline_i),
    .tr_req_o(tr_req_o),
    .tr_adr_o(tr_adr_o),
    .tr_ack_i(tr_ack_i),
    .tr_dat_i(tr_dat_i),
    .cc_ce_o(cc_ce_o),
    .cc_code_o(cc_code_o),
    .cc_scan_o(cc_scan_o),
    .cc_bmp_i(cc_bmp_i),
    .out_valid_o(out_valid_o),
    .out_rdy_i(out_rdy_i),
    .out_bmp_o(out_bmp_o),
    .out_attr_o(out_attr_o),
    .busy_o(busy_o),
    .line_done_o(line_done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int ack_count = 0;
  int pop_count = 0;
  int ack_delay = 1;
  int wait_cnt = 0;
  logic [15:0] exp_q[$];
  logic [12:0] adr_q[$];
  logic [8:0]  gl_p1 = 9'h155;
  logic [8:0]  gl_p2 = 9'h155;

  // Text RAM contents: one hand-placed cell with underline attribute, otherwise a hash of the address.
  function automatic logic [15:0] text_word(logic [12:0] adr);
    if (adr == 13'h0AAA) return 16'h8041;
    return {adr[6:0] ^ 7'h2B, adr[8:0] ^ 9'h0C3};
  endfunction

  function automatic logic [8:0] glyph(logic [8:0] code, logic [2:0] s);
    return code ^ {s, 6'b000000};
  endfunction

  function automatic logic [15:0] exp_entry(logic [12:0] adr, logic [2:0] s);
    logic [15:0] w;
    logic [8:0]  bmp;
    w   = text_word(adr);
    bmp = glyph(w[8:0], s);
`ifdef CHAR_FETCH_UNDERLINE_EN
    if (w[15] && (s == 3'd7)) bmp = 9'h1FF;
`endif
    return {bmp, w[15:9]};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Called at a negedge: drives a one-cycle line start and queues its expectations.
  task automatic applyStimulus(input logic [12:0] base, input logic [6:0] cols, input logic [2:0] s);
    logic [12:0] adr;
    row_base_i   = base;
    cols_i       = cols;
    scanline_i   = s;
    line_start_i = 1'b1;
    for (int c = 0; c <= int'(cols); c++) begin
      adr = base + 13'(c);
      adr_q.push_back(adr);
      exp_q.push_back(exp_entry(adr, s));
    end
    tick();
    line_start_i = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_count >= target) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL line_done_timeout: got %0d pulses, expected %0d", done_count, target);
  endtask

  task automatic finishLine(input string name, input int done_exp, input int pops_exp);
    repeat (3) tick();
    #2;
    checkOutput({name, "_done_count"}, 16'(done_count), 16'(done_exp));
    checkOutput({name, "_pops"}, 16'(pop_count), 16'(pops_exp));
    checkOutput({name, "_sb_empty"}, 16'(exp_q.size()), 16'd0);
    checkOutput({name, "_adr_empty"}, 16'(adr_q.size()), 16'd0);
    checkOutput({name, "_busy"}, {15'd0, busy_o}, 16'd0);
  endtask

  // Text RAM responder: acks after ack_delay request cycles and checks the address then.
  always @(negedge clk_i) begin
    if (rst_i) begin
      tr_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (tr_ack_i) begin
      tr_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (tr_req_o) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        if (adr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tr_adr: got 0x%0h, expected no request", tr_adr_o);
        end else begin
          checkOutput("tr_adr", {3'd0, tr_adr_o}, {3'd0, adr_q.pop_front()});
        end
        tr_dat_i = text_word(tr_adr_o);
        tr_ack_i = 1'b1;
        ack_count++;
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Character RAM: glyph row appears on cc_bmp_i two cycles after cc_ce_o, filler otherwise.
  always @(negedge clk_i) begin
    cc_bmp_i = gl_p2;
    gl_p2    = gl_p1;
    gl_p1    = cc_ce_o ? glyph(cc_code_o, cc_scan_o) : 9'h155;
  end

  // Scoreboard monitor: compares every accepted FIFO word against the queued expectation.
  always begin
    logic [15:0] e;
    @(negedge clk_i);
    #2;
    if (!rst_i && out_valid_o && out_rdy_i) begin
      pop_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL fifo_pop: got bmp 0x%0h attr 0x%0h, expected no entry", out_bmp_o, out_attr_o);
      end else begin
        e = exp_q.pop_front();
        checkOutput("fifo_bmp", {7'd0, out_bmp_o}, {7'd0, e[15:7]});
        checkOutput("fifo_attr", {9'd0, out_attr_o}, {9'd0, e[6:0]});
      end
    end
  end

  always begin
    @(negedge clk_i);
    #2;
    if (line_done_o) begin
      done_count++;
      checkOutput("busy_at_done", {15'd0, busy_o}, 16'd0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_done;
    rst_i        = 1'b1;
    line_start_i = 1'b0;
    row_base_i   = '0;
    cols_i       = '0;
    scanline_i   = '0;
    out_rdy_i    = 1'b1;
    tr_ack_i     = 1'b0;
    tr_dat_i     = '0;
    cc_bmp_i     = 9'h155;
    repeat (3) tick();
    #2;
    checkOutput("rst_tr_req", {15'd0, tr_req_o}, 16'd0);
    checkOutput("rst_cc_ce", {15'd0, cc_ce_o}, 16'd0);
    checkOutput("rst_valid", {15'd0, out_valid_o}, 16'd0);
    checkOutput("rst_busy", {15'd0, busy_o}, 16'd0);
    checkOutput("rst_done", {15'd0, line_done_o}, 16'd0);
    checkOutput("rst_tr_adr", {3'd0, tr_adr_o}, 16'd0);
    checkOutput("rst_cc_code", {7'd0, cc_code_o}, 16'd0);
    checkOutput("rst_out_bmp", {7'd0, out_bmp_o}, 16'd0);
    checkOutput("rst_out_attr", {9'd0, out_attr_o}, 16'd0);
    tick();
    rst_i = 1'b0;
    tick();

    $display("[TB] basic line: base 0x100, 3 columns");
    ack_delay = 1;
    pop_count = 0;
    applyStimulus(13'h0100, 7'd2, 3'd3);
    #2;
    checkOutput("busy_in_line", {15'd0, busy_o}, 16'd1);
    waitDone(1, 100);
    finishLine("basic", 1, 3);

    $display("[TB] address wrap: base 0x1FFF, 2 columns");
    pop_count = 0;
    tick();
    applyStimulus(13'h1FFF, 7'd1, 3'd2);
    waitDone(2, 100);
    finishLine("wrap", 2, 2);

    $display("[TB] back-pressure: out_rdy low, 8 columns");
    pop_count = 0;
    ack_count = 0;
    out_rdy_i = 1'b0;
    tick();
    applyStimulus(13'h0200, 7'd7, 3'd5);
    repeat (60) tick();
    #2;
    checkOutput("stall_valid", {15'd0, out_valid_o}, 16'd1);
    checkOutput("stall_tr_req", {15'd0, tr_req_o}, 16'd0);
    checkOutput("stall_busy", {15'd0, busy_o}, 16'd1);
    checkOutput("stall_acks", 16'(ack_count), 16'd5);
    checkOutput("stall_pops", 16'(pop_count), 16'd0);
    tick();
    out_rdy_i = 1'b1;
    waitDone(3, 200);
    finishLine("stall", 3, 8);

    $display("[TB] abort during fetch of column 5");
    ack_delay = 4;
    pop_count = 0;
    base_done = done_count;
    tick();
    applyStimulus(13'h0300, 7'd7, 3'd1);
    for (int i = 0; i < 300; i++) begin
      if (tr_req_o && (tr_adr_o == 13'h0303)) break;
      tick();
    end
    out_rdy_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tr_req_o && (tr_adr_o == 13'h0305)) break;
      tick();
    end
    tick();
    #2;
    checkOutput("abort_pre_valid", {15'd0, out_valid_o}, 16'd1);
    checkOutput("abort_pre_pops", 16'(pop_count), 16'd2);
    tick();
    exp_q.delete();
    adr_q.delete();
    pop_count = 0;
    applyStimulus(13'h0400, 7'd2, 3'd4);
    #2;
    checkOutput("abort_flushed", {15'd0, out_valid_o}, 16'd0);
    checkOutput("abort_tr_req", {15'd0, tr_req_o}, 16'd1);
    checkOutput("abort_tr_adr", {3'd0, tr_adr_o}, 16'h0400);
    checkOutput("abort_no_done", 16'(done_count), 16'(base_done));
    out_rdy_i = 1'b1;
    waitDone(base_done + 1, 200);
    finishLine("abort", base_done + 1, 3);

    $display("[TB] underline cell: word 0x8041, scanline 7");
    ack_delay = 1;
    pop_count = 0;
    tick();
    applyStimulus(13'h0AAA, 7'd0, 3'd7);
    waitDone(base_done + 2, 100);
    finishLine("underline", base_done + 2, 1);

    $display("[TB] full width: 128 columns from 0x1FC0");
    pop_count = 0;
    tick();
    applyStimulus(13'h1FC0, 7'd127, 3'd2);
    waitDone(base_done + 3, 2000);
    finishLine("wide", base_done + 3, 128);

    $display("[TB] reset during WAIT1");
    pop_count = 0;
    tick();
    applyStimulus(13'h0500, 7'd3, 3'd6);
    for (int i = 0; i < 100; i++) begin
      if (cc_ce_o) break;
      tick();
    end
    tick();
    rst_i = 1'b1;
    exp_q.delete();
    adr_q.delete();
    tick();
    #2;
    checkOutput("rst_mid_tr_req", {15'd0, tr_req_o}, 16'd0);
    checkOutput("rst_mid_cc_ce", {15'd0, cc_ce_o}, 16'd0);
    checkOutput("rst_mid_busy", {15'd0, busy_o}, 16'd0);
    checkOutput("rst_mid_valid", {15'd0, out_valid_o}, 16'd0);
    checkOutput("rst_mid_cc_code", {7'd0, cc_code_o}, 16'd0);
    checkOutput("rst_mid_cc_scan", {13'd0, cc_scan_o}, 16'd0);
    tick();
    rst_i = 1'b0;
    repeat (10) tick();
    #2;
    checkOutput("rst_after_valid", {15'd0, out_valid_o}, 16'd0);
    checkOutput("rst_after_busy", {15'd0, busy_o}, 16'd0);
    checkOutput("rst_after_done", 16'(done_count), 16'(base_done + 3));
    checkOutput("rst_after_pops", 16'(pop_count), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_fetch_ctrl.md
CHAR_FETCH_CTRL -- requirements
Module: char_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, 2..16).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all ports are synchronous to it.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port line_start_i, input, 1 bit: one-cycle pulse that starts fetching one text scanline.
REQ-005 The block SHALL have port row_base_i, input, 13 bits: text-RAM address of column 0 of the current row, sampled on line_start_i.
REQ-006 The block SHALL have port cols_i, input, 7 bits: column count minus 1 (1..128 columns), sampled on line_start_i.
REQ-007 The block SHALL have port scanline_i, input, 3 bits: glyph scanline, sampled on line_start_i.
REQ-008 The block SHALL have ports tr_req_o (out, 1), tr_adr_o (out, 13), tr_ack_i (in, 1) and tr_dat_i (in, 16): the text-RAM read port; tr_dat_i[8:0] is the char code and tr_dat_i[15:9] the attribute.
REQ-009 The block SHALL have ports cc_ce_o (out, 1), cc_code_o (out, 9), cc_scan_o (out, 3) and cc_bmp_i (in, 9): the character-RAM glyph port; bitmap valid 2 cycles after cc_ce_o.
REQ-010 The block SHALL have ports out_valid_o (out, 1), out_rdy_i (in, 1), out_bmp_o (out, 9) and out_attr_o (out, 7): the FIFO output to the pixel shifter.
REQ-011 The block SHALL have ports busy_o (out, 1), a level high while a line is in progress, and line_done_o (out, 1), a one-cycle pulse when the last column has been pushed.

Function
REQ-012 The state machine SHALL have states IDLE, FETCH, GLYPH, WAIT1, WAIT2 and PUSH.
REQ-013 IDLE: on line_start_i the block SHALL clear col to 0, latch the inputs and go to FETCH.
REQ-014 FETCH: tr_req_o SHALL be 1 with tr_adr_o = (row_base + col) mod 8192; on tr_ack_i the block SHALL latch tr_dat_i, drop tr_req_o in the next cycle and go to GLYPH.
REQ-015 FETCH: tr_req_o and tr_adr_o SHALL be held stable until ack; the wait is unbounded.
REQ-016 GLYPH: cc_ce_o SHALL be 1 for exactly one cycle, with cc_code_o = latched code and cc_scan_o = latched scanline; the state then SHALL go to WAIT1 and then WAIT2.
REQ-017 WAIT2: the block SHALL capture cc_bmp_i as the bitmap and go to PUSH.
REQ-018 PUSH: if the FIFO is not full, the block SHALL write {bitmap, attr}; if col == cols it SHALL pulse line_done_o and go to IDLE, else it SHALL increment col and go to FETCH. If the FIFO is full, it SHALL stall in PUSH.
REQ-019 The FIFO SHALL be first-word fall-through: out_valid_o = not empty; a pop occurs when out_valid_o and out_rdy_i are both high.
REQ-020 A simultaneous push and pop on a full FIFO SHALL be handled as follows: the push stalls that cycle and occurs in the next cycle; the pop proceeds.
REQ-021 A simultaneous push and pop on an empty FIFO SHALL leave the FIFO with 1 entry and out_valid_o = 0 in that cycle.
REQ-022 line_start_i outside IDLE SHALL abort the line: the FIFO is flushed, a pending tr_req_o is dropped, no line_done_o is pulsed, and the new line restarts at FETCH with freshly sampled inputs.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 Per-column throughput SHALL be 5 cycles plus the ack wait plus the full-stall cycles.
REQ-025 The col counter SHALL be 7 bits; cols_i = 127 SHALL yield 128 columns with no overflow before termination.

Reset
REQ-026 rst_i SHALL force IDLE, col = 0, and an empty FIFO.
REQ-027 During reset, tr_req_o, cc_ce_o, out_valid_o, busy_o and line_done_o SHALL be 0.
REQ-028 During reset, tr_adr_o, cc_code_o, cc_scan_o, out_bmp_o and out_attr_o SHALL be 0.
REQ-029 Reset mid-line SHALL discard all state; no pulse is emitted; reset has priority over line_start_i.

Configuration
REQ-030 Macro CHAR_FETCH_UNDERLINE_EN SHALL control underline insertion.
REQ-031 When CHAR_FETCH_UNDERLINE_EN is defined: if attr bit 6 is 1 and scanline == 7, the pushed bitmap SHALL be 9'h1FF regardless of cc_bmp_i.
REQ-032 When CHAR_FETCH_UNDERLINE_EN is undefined, the bitmap SHALL always be passed through unmodified, and attr bit 6 SHALL be carried unchanged.

Verification
REQ-033 Scenario: row_base=0x100, cols=2, scan=3, ack 1 cycle after req, out_rdy=1 -> addresses 0x100, 0x101, 0x102; 3 FIFO pops in order; line_done_o pulses once; busy_o falls the next cycle.
REQ-034 Scenario: row_base=0x1FFF, cols=1 -> addresses 0x1FFF, then 0x0000.
REQ-035 Scenario: out_rdy=0, cols=7, FIFO_DEPTH=4 -> 4 entries held, FSM stalled in PUSH, tr_req_o=0; raising out_rdy drains all 8 entries in order.
REQ-036 Scenario: line_start_i pulsed during FETCH of col 5 -> FIFO empty next cycle, new row_base on tr_adr_o, no line_done_o.
REQ-037 Scenario: tr_dat_i=0x8041, scan=7 -> out_bmp_o=0x1FF with CHAR_FETCH_UNDERLINE_EN defined, and = cc_bmp_i without it; out_attr_o=0x40 in both cases.
REQ-038 Scenario: rst_i asserted in WAIT1 -> next cycle all outputs 0; an ignored bitmap arrives and is never pushed.
